// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: opcodes, FSM states and control word shared by the adder sequencer.
package adder_seq_pkg;
  typedef enum logic [2:0] {OP_NOP = 3'd0, OP_LDA, OP_ADD, OP_SUB, OP_OUT} opcode_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_EXEC, S_OUTP, S_DONE} state_t;
  typedef struct packed {
    logic load_bus;
    logic nla;
    logic nlb;
    logic eu;
    logic sub;
    logic out_sel;
  } ctrl_t;
  localparam ctrl_t CTRL_IDLE = '{load_bus: 1'b0, nla: 1'b1, nlb: 1'b1, eu: 1'b0, sub: 1'b0, out_sel: 1'b0};
endpackage

// File: rtl/adder_sequencer_if.sv
// adder_sequencer_if: command valid/ready handshake into the sequencer.
interface adder_sequencer_if #(parameter int DATA_W = 8);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/adder_seq_cmd_fifo.sv
// adder_seq_cmd_fifo: 2-entry command FIFO; push while full succeeds only alongside a pop.
module adder_seq_cmd_fifo #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wp, rp, wr, rd;
  logic [1:0]   cnt;
  assign full  = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign dout  = mem[rp];
  always_ff @(posedge clk) if (wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (wr) wp <= !wp;
      if (rd) rp <= !rp;
      cnt <= cnt + 2'(wr) - 2'(rd);
    end
endmodule

// File: rtl/adder_sequencer.sv
// adder_sequencer: expands LDA/ADD/SUB/OUT/NOP commands into per-cycle datapath control.
// Define ADDER_SEQ_FIFO_EN to place a 2-entry command FIFO in front of the FSM.
module adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OUT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_sequencer_if.slave    cmd,
  output logic [DATA_W-1:0]   operand_out,
  output logic                load_bus,
  output logic                nla,
  output logic                nlb,
  output logic                eu,
  output logic                sub,
  output logic                out_sel,
  input  logic                zf_in,
  input  logic                cf_in,
  output logic                zf_q,
  output logic                cf_q,
  output logic                done,
  output logic                err_sticky
);
  state_t            state, state_n;
  ctrl_t             ctrl, ctrl_n;
  logic [3:0]        cnt, cnt_n;
  logic [2:0]        op_q, acc_op;
  logic [DATA_W-1:0] acc_data;
  logic              acc, idle;
  assign idle = state == S_IDLE;
`ifdef ADDER_SEQ_FIFO_EN
  logic full, empty;
  adder_seq_cmd_fifo #(.W(3 + DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd.cmd_valid && cmd.cmd_ready),
    .din   ({cmd.cmd_op, cmd.cmd_data}),
    .pop   (acc),
    .dout  ({acc_op, acc_data}),
    .full  (full),
    .empty (empty)
  );
  assign cmd.cmd_ready = rst_n && !full;
  assign acc           = idle && !empty;
`else
  assign cmd.cmd_ready = rst_n && idle;
  assign acc           = cmd.cmd_valid && cmd.cmd_ready;
  assign acc_op        = cmd.cmd_op;
  assign acc_data      = cmd.cmd_data;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        cnt_n = 4'(OUT_CYCLES - 1);
        if (acc)
          state_n = (acc_op == OP_LDA || acc_op == OP_ADD || acc_op == OP_SUB) ? S_FETCH :
                    acc_op == OP_OUT ? S_OUTP : S_DONE;
      end
      S_FETCH: state_n = S_LOAD;
      S_LOAD:  state_n = op_q == OP_LDA ? S_DONE : S_EXEC;
      S_EXEC:  state_n = S_DONE;
      S_OUTP: begin
        state_n = cnt == 4'd0 ? S_DONE : S_OUTP;
        cnt_n   = cnt - 4'd1;
      end
      default: state_n = S_IDLE;
    endcase
    // Decode from next state so the registered word lines up with the state it describes
    ctrl_n          = CTRL_IDLE;
    ctrl_n.load_bus = state_n == S_FETCH || state_n == S_LOAD;
    ctrl_n.nla      = !(state_n == S_EXEC || (state_n == S_LOAD && op_q == OP_LDA));
    ctrl_n.nlb      = !(state_n == S_LOAD && op_q != OP_LDA);
    ctrl_n.eu       = state_n == S_EXEC;
    ctrl_n.sub      = state_n == S_EXEC && op_q == OP_SUB;
    ctrl_n.out_sel  = state_n == S_OUTP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= S_IDLE;
      ctrl        <= CTRL_IDLE;
      cnt         <= 4'd0;
      op_q        <= 3'd0;
      operand_out <= '0;
      zf_q        <= 1'b0;
      cf_q        <= 1'b0;
      done        <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      state <= state_n;
      ctrl  <= ctrl_n;
      cnt   <= cnt_n;
      done  <= state_n == S_DONE;
      if (acc) begin
        op_q        <= acc_op;
        operand_out <= acc_data;
      end
      if (acc && acc_op > 3'd4) err_sticky <= 1'b1;
      if (state == S_DONE && (op_q == OP_ADD || op_q == OP_SUB)) begin
        zf_q <= zf_in;
        cf_q <= cf_in;
      end
    end
  assign {load_bus, nla, nlb, eu, sub, out_sel} = ctrl;
endmodule

// File: tb/tb_adder_sequencer.sv
// tb_adder_sequencer: directed command vectors against a behavioural A/B/ALU datapath.
module tb_adder_sequencer;
  import adder_seq_pkg::*;
`ifdef ADDER_SEQ_FIFO_EN
  localparam int LAT_ADJ = 1;
`else
  localparam int LAT_ADJ = 0;
`endif
  localparam logic [6:0] W_IDLE  = 7'b0110000;
  localparam logic [6:0] W_FETCH = 7'b1110000;
  localparam logic [6:0] W_LDA   = 7'b1010000;
  localparam logic [6:0] W_LDB   = 7'b1100000;
  localparam logic [6:0] W_ADD   = 7'b0011000;
  localparam logic [6:0] W_SUB   = 7'b0011100;
  localparam logic [6:0] W_OUT   = 7'b0110010;
  localparam logic [6:0] W_DONE  = 7'b0110001;
  typedef struct {
    logic [2:0]      op;
    logic [7:0]      data;
    logic [5:0][6:0] tr;
    logic [7:0]      a;
    logic            zf;
    logic            cf;
    logic            err;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] operand_out;
  logic load_bus, nla, nlb, eu, sub, out_sel, zf_in, cf_in, zf_q, cf_q, done, err_sticky;
  logic [6:0] word;
  logic [7:0] ra, rb, rbuf, bus;
  logic [8:0] alu;
  logic zr, cr;
  int total = 0, bad = 0;
  vec_t v [14];
  adder_sequencer_if #(.DATA_W(8)) cif ();
  adder_sequencer #(.DATA_W(8), .OUT_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cif.slave), .operand_out(operand_out),
    .load_bus(load_bus), .nla(nla), .nlb(nlb), .eu(eu), .sub(sub), .out_sel(out_sel),
    .zf_in(zf_in), .cf_in(cf_in), .zf_q(zf_q), .cf_q(cf_q), .done(done), .err_sticky(err_sticky)
  );
  always #5 clk = !clk;
  assign word  = {load_bus, nla, nlb, eu, sub, out_sel, done};
  assign alu   = {1'b0, ra} + {1'b0, sub ? ~rb : rb} + 9'(sub);
  assign bus   = load_bus ? rbuf : eu ? alu[7:0] : 8'h00;
  assign zf_in = zr;
  assign cf_in = cr;
  // Datapath: input buffer, A/B registers and an ALU whose flags are registered with A
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra <= 8'h00; rb <= 8'h00; rbuf <= 8'h00; zr <= 1'b0; cr <= 1'b0;
    end else begin
      if (load_bus) rbuf <= operand_out;
      if (!nlb) rb <= bus;
      if (!nla) ra <= eu ? alu[7:0] : bus;
      if (!nla && eu) begin
        zr <= alu[7:0] == 8'h00;
        cr <= alu[8];
      end
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  function automatic logic [5:0][6:0] mk(input logic [6:0] w0, w1, w2, w3, w4);
    logic [5:0][6:0] t;
    logic [4:0][6:0] w;
    w = {w4, w3, w2, w1, w0};
    for (int k = 0; k < 6; k++) t[k] = W_IDLE;
    for (int k = 0; k < 5; k++) if (k + LAT_ADJ < 6) t[k + LAT_ADJ] = w[k];
    return t;
  endfunction
  task automatic offer(input logic [2:0] op, input logic [7:0] data, input string nm);
    int k = 0;
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = data;
    while (!cif.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, ".accept"}, 32'(cif.cmd_ready), 32'd1);
  endtask
  task automatic run(input int n);
    offer(v[n].op, v[n].data, $sformatf("v%0d", n));
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("v%0d.trace%0d", n, i), 32'(word), 32'(v[n].tr[i]));
      if (i < 5) @(negedge clk);
    end
    chk($sformatf("v%0d.a", n), 32'(ra), 32'(v[n].a));
    chk($sformatf("v%0d.zf", n), 32'(zf_q), 32'(v[n].zf));
    chk($sformatf("v%0d.cf", n), 32'(cf_q), 32'(v[n].cf));
    chk($sformatf("v%0d.err", n), 32'(err_sticky), 32'(v[n].err));
    chk($sformatf("v%0d.operand", n), 32'(operand_out), 32'(v[n].data));
  endtask
  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 3'd0;
    cif.cmd_data  = 8'h00;
    v[0]  = '{OP_LDA, 8'h2A, mk(W_FETCH, W_LDA, W_DONE, W_IDLE, W_IDLE), 8'h2A, 1'b0, 1'b0, 1'b0};
    v[1]  = '{OP_LDA, 8'h05, mk(W_FETCH, W_LDA, W_DONE, W_IDLE, W_IDLE), 8'h05, 1'b0, 1'b0, 1'b0};
    v[2]  = '{OP_ADD, 8'h03, mk(W_FETCH, W_LDB, W_ADD, W_DONE, W_IDLE), 8'h08, 1'b0, 1'b0, 1'b0};
    v[3]  = '{OP_LDA, 8'h07, mk(W_FETCH, W_LDA, W_DONE, W_IDLE, W_IDLE), 8'h07, 1'b0, 1'b0, 1'b0};
    v[4]  = '{OP_SUB, 8'h07, mk(W_FETCH, W_LDB, W_SUB, W_DONE, W_IDLE), 8'h00, 1'b1, 1'b1, 1'b0};
    v[5]  = '{OP_LDA, 8'hFF, mk(W_FETCH, W_LDA, W_DONE, W_IDLE, W_IDLE), 8'hFF, 1'b1, 1'b1, 1'b0};
    v[6]  = '{OP_ADD, 8'h01, mk(W_FETCH, W_LDB, W_ADD, W_DONE, W_IDLE), 8'h00, 1'b1, 1'b1, 1'b0};
    v[7]  = '{OP_LDA, 8'h80, mk(W_FETCH, W_LDA, W_DONE, W_IDLE, W_IDLE), 8'h80, 1'b1, 1'b1, 1'b0};
    v[8]  = '{OP_ADD, 8'h90, mk(W_FETCH, W_LDB, W_ADD, W_DONE, W_IDLE), 8'h10, 1'b0, 1'b1, 1'b0};
    v[9]  = '{OP_LDA, 8'h03, mk(W_FETCH, W_LDA, W_DONE, W_IDLE, W_IDLE), 8'h03, 1'b0, 1'b1, 1'b0};
    v[10] = '{OP_SUB, 8'h05, mk(W_FETCH, W_LDB, W_SUB, W_DONE, W_IDLE), 8'hFE, 1'b0, 1'b0, 1'b0};
    v[11] = '{OP_OUT, 8'h55, mk(W_OUT, W_OUT, W_OUT, W_DONE, W_IDLE), 8'hFE, 1'b0, 1'b0, 1'b0};
    v[12] = '{OP_NOP, 8'h00, mk(W_DONE, W_IDLE, W_IDLE, W_IDLE, W_IDLE), 8'hFE, 1'b0, 1'b0, 1'b0};
    v[13] = '{3'b110, 8'h11, mk(W_DONE, W_IDLE, W_IDLE, W_IDLE, W_IDLE), 8'hFE, 1'b0, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst.ready_low", 32'(cif.cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.word", 32'(word), 32'(W_IDLE));
    chk("rst.flags_err", 32'({zf_q, cf_q, err_sticky}), 32'd0);
    chk("rst.operand", 32'(operand_out), 32'd0);
    chk("rst.ready", 32'(cif.cmd_ready), 32'd1);
    for (int n = 0; n < 14; n++) run(n);
    begin
      int k = 0;
      offer(OP_ADD, 8'h02, "rst_exec");
      @(negedge clk);
      cif.cmd_valid = 1'b0;
      while (!eu && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk("rst_exec.reach_exec", 32'(eu), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_exec.word", 32'(word), 32'(W_IDLE));
      chk("rst_exec.err", 32'(err_sticky), 32'd0);
      chk("rst_exec.ready", 32'(cif.cmd_ready), 32'd0);
      chk("rst_exec.operand", 32'(operand_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_exec.ready_after", 32'(cif.cmd_ready), 32'd1);
    end
`ifdef ADDER_SEQ_FIFO_EN
    begin
      int dones = 0;
      offer(OP_LDA, 8'h11, "fifo0");
      offer(OP_LDA, 8'h22, "fifo1");
      offer(OP_LDA, 8'h33, "fifo2");
      @(negedge clk);
      cif.cmd_valid = 1'b0;
      chk("fifo.full_ready", 32'(cif.cmd_ready), 32'd0);
      for (int i = 0; i < 20; i++) begin
        dones += int'(done);
        @(negedge clk);
      end
      chk("fifo.dones", 32'(dones), 32'd3);
      chk("fifo.a", 32'(ra), 32'h33);
      chk("fifo.ready_after", 32'(cif.cmd_ready), 32'd1);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_sequencer.md
Name: adder_sequencer

Overview:
Microsequencer for the adder/accumulator datapath (A register, B register, add/sub ALU, registered input buffer onto the shared bus). Accepts one command at a time (opcode + immediate operand) over a valid/ready handshake. Expands each command into the per-cycle control word: bus load, active-low A/B loads, ALU enable, subtract, output select. Captures ALU flags after arithmetic and reports completion with a one-cycle done pulse.

Parameters:
DATA_W, 8, width of the operand and the datapath bus.
OUT_CYCLES, 1, cycles out_sel is held for OUT; legal range 1..15.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept
cmd_op  in  3  opcode: 000 NOP, 001 LDA, 010 ADD, 011 SUB, 100 OUT, 101-111 illegal
cmd_data  in  DATA_W  immediate operand
operand_out  out  DATA_W  value driven to the datapath input buffer
load_bus  out  1  input buffer drives the bus
nla  out  1  A register load, active low
nlb  out  1  B register load, active low
eu  out  1  ALU result onto the bus
sub  out  1  ALU subtract select
out_sel  out  1  1 = bus to output pins, 0 = A register to output pins
zf_in  in  1  ALU zero flag
cf_in  in  1  ALU carry flag
zf_q  out  1  captured zero flag
cf_q  out  1  captured carry flag
done  out  1  one-cycle completion pulse
err_sticky  out  1  illegal opcode seen

Behaviour:
- Idle control word: nla=1, nlb=1; load_bus, eu, sub, out_sel = 0; operand_out holds its last value.
- Reset: state IDLE. Idle control word. operand_out, zf_q, cf_q, done, err_sticky = 0. cmd_ready forced 0 while rst_n low.
- Reset mid-command: the command is dropped and outputs return to idle values immediately (asynchronous).
- Accept: on cmd_valid && cmd_ready. cmd_ready = 1 only in IDLE.
- On accept, opcode is latched and cmd_data is latched into operand_out.
- State machine: IDLE, FETCH, LOAD, EXEC, OUTP, DONE.
  - Accept: NOP/illegal -> DONE. LDA/ADD/SUB -> FETCH. OUT -> OUTP.
  - FETCH (1 cycle): load_bus=1; the buffer captures operand_out at the cycle end.
  - LOAD (1 cycle): load_bus=1. LDA: nla=0, then -> DONE. ADD/SUB: nlb=0, then -> EXEC.
  - EXEC (1 cycle): eu=1, nla=0 (A <= A±B), load_bus=0; sub=1 for SUB only. -> DONE.
  - OUTP: out_sel=1 for exactly OUT_CYCLES cycles, then -> DONE.
  - DONE (1 cycle): done=1, idle control word. -> IDLE.
- Flags: in DONE of ADD/SUB, zf_q<=zf_in and cf_q<=cf_in. Other opcodes hold the flags.
- Latency, accept edge to done high: NOP 1 cycle, LDA 3, ADD/SUB 4, OUT OUT_CYCLES+1. Next accept is possible the cycle after done.
- Illegal opcode: no control activity, executes as NOP, err_sticky<=1. Cleared only by reset.
- cmd_valid while busy: ignored (ready=0). The requester must hold the command.
- Control outputs are registered from next-state; glitch-free.

Optional Feature:
ADDER_SEQ_FIFO_EN.
- Defined: a 2-entry command FIFO sits in front of the FSM.
  - cmd_ready = !fifo_full, independent of FSM state.
  - The FSM pops the head when in IDLE and the FIFO is non-empty. The pop cycle counts as accept, adding 1 cycle to every latency above.
  - Push and pop in the same cycle when full is allowed.
  - Reset empties the FIFO.
- Undefined: no FIFO; cmd_ready as in Behaviour.

Decomposition:
- Package adder_seq_pkg holds:
  - opcode enum (3 bits)
  - state enum
  - control-word struct {load_bus, nla, nlb, eu, sub, out_sel}
  - constant CTRL_IDLE
- Sub-module adder_seq_cmd_fifo (depth 2, width 3+DATA_W), instantiated only under ADDER_SEQ_FIFO_EN.

Test Plan:
- Reset, then release -> nla=nlb=1, load_bus/eu/sub/out_sel/done/zf_q/cf_q/err_sticky=0, cmd_ready=1.
- LDA 0x2A -> load_bus=1 for 2 cycles with nla=0 in the 2nd; done in the 3rd cycle after accept; datapath model A=0x2A.
- LDA 5, then ADD 3 -> nlb=0 in LOAD; eu=1, sub=0, nla=0 in EXEC; done in cycle 4; A=8, zf_q=0, cf_q=0.
- LDA 7, then SUB 7 -> sub=1 only in EXEC; A=0, zf_q=1 after done. Then LDA 0xFF, ADD 1 -> cf_q=1, zf_q=1.
- OUT with OUT_CYCLES=3 -> out_sel=1 for exactly 3 cycles, done on the 4th; flags unchanged.
- Opcode 110 -> no control pulses, done after 1 cycle, err_sticky=1. Then rst_n low during EXEC of ADD -> all controls idle immediately, err_sticky=0. With ADDER_SEQ_FIFO_EN: 3 back-to-back commands -> ready drops on the 3rd until a pop occurs.
